// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronised rx, half-bit start qualification,
// mid-bit sampling, one-cycle dv / frame_err strobes.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       dv,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);

    generate
        if (BAUD_DIV < 4) begin : g_bad_div
            $error("uart_byte_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        dv_q, dv_d;
    logic        ferr_q, ferr_d;

    logic        rx_m_q;
    logic        rx_s_q;
    logic        rx_d_q;

    logic        bit_done;
    logic        half_done;
    logic        fall;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
            rx_d_q <= rx_s_q;
        end
    end

    assign bit_done  = (cnt_q == BAUD_LAST);
    assign half_done = (cnt_q == HALF_LAST);
    assign fall      = rx_d_q & ~rx_s_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (half_done) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line already high again at mid start bit is a glitch.
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dv        = dv_q;
    assign frame_err = ferr_q;
    assign data      = data_q;
    assign busy      = (state_q != IDLE);

    a_strobe_excl : assert property (
        @(posedge clk) disable iff (rst) !(dv_q && ferr_q)
    );

    a_cnt_range : assert property (
        @(posedge clk) disable iff (rst) (cnt_q <= BAUD_LAST)
    );

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: a frame-level expectation queue
// checked every cycle, plus literal checkpoints.
module tb_uart_byte_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       dv;
    logic [7:0] data;
    logic       frame_err;
    logic       busy;

    uart_byte_rx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .dv       (dv),
        .data     (data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    localparam int BIT = 16;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int fall_cyc = 0;
    int last_lat = -1;
    int dv_cnt   = 0;
    int ferr_cnt = 0;

    logic       rst_seen = 1'b0;
    logic       dv_prev  = 1'b0;
    logic       busy_seen = 1'b0;
    logic [7:0] model_data = 8'h00;

    // bit 8 set = frame error expected, else byte in [7:0]
    logic [8:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (rst_seen) begin
            model_data = 8'h00;
            chk("reset_state", {dv, frame_err, busy, data}, 0);
        end else begin
            if (dv || frame_err) begin
                chk("strobe_excl", int'(dv && frame_err), 0);
            end
            if (dv) begin
                dv_cnt++;
                if (!dv_prev) last_lat = cyc - fall_cyc;
                if (exp_q.size() == 0 || exp_q[0][8]) begin
                    chk("unexpected_dv", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dv_data", data, e[7:0]);
                    model_data = e[7:0];
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                if (exp_q.size() == 0 || !exp_q[0][8]) begin
                    chk("unexpected_frame_err", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_err_event", 1, 1);
                end
            end
            chk("data_hold", data, model_data);
        end
        dv_prev = dv;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One 10-bit 8N1 frame; rst_at >= 0 pulses reset at that tick and abandons.
    task automatic send(input logic [7:0] b, input logic stop,
                        input int rst_at);
        int bi;
        if (rst_at < 0) exp_q.push_back(stop ? {1'b0, b} : 9'h100);
        for (int t = 0; t < 10 * BIT; t++) begin
            if (t == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                rx  = 1'b1;
                return;
            end
            bi = t / BIT;
            if (bi == 0)      rx = 1'b0;
            else if (bi <= 8) rx = b[bi-1];
            else              rx = stop;
            if (t == 0) fall_cyc = cyc;
            tick();
        end
    endtask

    initial begin
        logic [7:0] word[7];
        int         n;
        word = '{8'h57, 8'h65, 8'h6C, 8'h63, 8'h6F, 8'h6D, 8'h65};

        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(5);
        chk("idle_busy", busy, 0);
        chk("idle_data", data, 8'h00);

        send(8'h57, 1'b1, -1);
        rx = 1'b1;
        idle(4);
        chk("single_data", data, 8'h57);
        chk("single_dv_count", dv_cnt, 1);
        chk("single_busy_low", busy, 0);
        chk("single_no_ferr", ferr_cnt, 0);

        n = dv_cnt;
        foreach (word[i]) send(word[i], 1'b1, -1);
        rx = 1'b1;
        idle(4);
        chk("stream_dv_count", dv_cnt - n, 7);
        chk("stream_last_data", data, 8'h65);
        chk("stream_queue_empty", exp_q.size(), 0);

        n = dv_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3);
        chk("glitch_busy_rise", busy_seen, 1);
        idle(10);
        chk("glitch_busy_fall", busy, 0);
        chk("glitch_no_dv", dv_cnt - n, 0);
        chk("glitch_no_ferr", ferr_cnt, 0);

        n = dv_cnt;
        send(8'hA5, 1'b0, -1);
        idle(24);
        rx = 1'b1;
        idle(30);
        chk("frame_err_count", ferr_cnt, 1);
        chk("frame_no_dv", dv_cnt - n, 0);
        chk("frame_data_kept", data, 8'h65);
        chk("frame_busy_low", busy, 0);

        send(8'hC3, 1'b1, -1);
        rx = 1'b1;
        idle(4);
        chk("fresh_edge_data", data, 8'hC3);

        n = dv_cnt;
        send(8'h3C, 1'b1, 5 * BIT + BIT / 2);
        idle(20);
        chk("abort_data_reset", data, 8'h00);
        chk("abort_busy_low", busy, 0);
        chk("abort_no_strobe", dv_cnt - n + ferr_cnt - 1, 0);
        send(8'h81, 1'b1, -1);
        rx = 1'b1;
        idle(4);
        chk("after_abort_data", data, 8'h81);
        chk("after_abort_dv", dv_cnt - n, 1);

        send(8'h00, 1'b1, -1);
        rx = 1'b1;
        idle(4);
        chk("latency_data", data, 8'h00);
        chk("latency_in_window", int'(last_lat >= 154 && last_lat <= 156), 1);
        if (last_lat != 155) $display("note latency=%0d", last_lat);

        idle(10);
        chk("total_dv", dv_cnt, 11);
        chk("total_ferr", ferr_cnt, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
